// File: rtl/mcc_control_unit_pkg.sv
// Shared constants for the multi-cycle 24-bit CPU control unit: opcodes,
// ALU operations, FSM state encoding and datapath mux encodings.
package mcc_control_unit_pkg;

   localparam int DATA_W_DEF = 24;
   localparam int ADDR_W_DEF = 11;
   localparam int OP_W_DEF   = 4;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5
   } state_t;

   localparam logic [3:0] OPC_NOP  = 4'd0;
   localparam logic [3:0] OPC_ADD  = 4'd1;
   localparam logic [3:0] OPC_SUB  = 4'd2;
   localparam logic [3:0] OPC_AND  = 4'd3;
   localparam logic [3:0] OPC_OR   = 4'd4;
   localparam logic [3:0] OPC_XOR  = 4'd5;
   localparam logic [3:0] OPC_SLL  = 4'd6;
   localparam logic [3:0] OPC_SRL  = 4'd7;
   localparam logic [3:0] OPC_ADDI = 4'd8;
   localparam logic [3:0] OPC_LW   = 4'd9;
   localparam logic [3:0] OPC_SW   = 4'd10;
   localparam logic [3:0] OPC_BEQ  = 4'd11;
   localparam logic [3:0] OPC_BNE  = 4'd12;
   localparam logic [3:0] OPC_JMP  = 4'd13;
   localparam logic [3:0] OPC_SLT  = 4'd14;
   localparam logic [3:0] OPC_HALT = 4'd15;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLL  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SLT  = 4'd7;
   localparam logic [3:0] ALU_PASS = 4'd8;

   localparam logic [1:0] PCS_ALU   = 2'd0;
   localparam logic [1:0] PCS_BUF   = 2'd1;
   localparam logic [1:0] PCS_JUMP  = 2'd2;
   localparam logic [1:0] PCS_RESET = 2'd3;

   localparam logic       SRCA_PC   = 1'b0;
   localparam logic       SRCA_REGA = 1'b1;

   localparam logic [1:0] SRCB_REGB = 2'd0;
   localparam logic [1:0] SRCB_ONE  = 2'd1;
   localparam logic [1:0] SRCB_IMM  = 2'd2;
   localparam logic [1:0] SRCB_1023 = 2'd3;

   // Maps an R-type opcode onto the ALU operation it executes.
   function automatic logic [3:0] rtype_alu_op(input logic [3:0] opc);
      logic [3:0] op;
      case (opc)
         OPC_ADD: op = ALU_ADD;
         OPC_SUB: op = ALU_SUB;
         OPC_AND: op = ALU_AND;
         OPC_OR:  op = ALU_OR;
         OPC_XOR: op = ALU_XOR;
         OPC_SLL: op = ALU_SLL;
         OPC_SRL: op = ALU_SRL;
         OPC_SLT: op = ALU_SLT;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/mcc_alu.sv
// Combinational ALU of the multi-cycle CPU, with a zero flag on the result.
module mcc_alu
   import mcc_control_unit_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic [3:0]        alu_op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] result,
   output logic              zero
);

   logic [4:0] shamt_s;
   logic       shift_ok_s;

   assign shamt_s    = b[4:0];
   assign shift_ok_s = (32'(shamt_s) < 32'(DATA_W));

   // Operation select; shifts past the word width flush to zero.
   always_comb begin
      result = '0;
      case (alu_op)
         ALU_ADD:  result = a + b;
         ALU_SUB:  result = a - b;
         ALU_AND:  result = a & b;
         ALU_OR:   result = a | b;
         ALU_XOR:  result = a ^ b;
         ALU_SLL:  result = shift_ok_s ? (a << shamt_s) : '0;
         ALU_SRL:  result = shift_ok_s ? (a >> shamt_s) : '0;
         ALU_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_PASS: result = b;
         default:  result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/mcc_fsm.sv
// Multi-cycle control FSM: Moore strobes per state plus the Mealy branch
// PC write, which depends on the ALU zero flag during EXEC.
module mcc_fsm
   import mcc_control_unit_pkg::*;
#(
   parameter int OP_W = OP_W_DEF
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [OP_W-1:0] opcode,
   input  logic            zero,
   output logic            ir_write,
   output logic            reg_write,
   output logic            mem_select,
   output logic            mem_to_reg,
   output logic            mem_read_not_write,
   output logic [1:0]      pc_source,
   output logic            alu_src_a,
   output logic [1:0]      alu_src_b,
   output logic [3:0]      alu_op,
   output logic            pc_write
);

   state_t     state_r;
   state_t     next_state_s;
   logic [3:0] opc_s;

   assign opc_s = 4'(opcode);

   // State register; reset aborts any instruction in flight.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= ST_FETCH;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state sequencing by opcode.
   always_comb begin
      next_state_s = ST_FETCH;
      case (state_r)
         ST_FETCH:  next_state_s = ST_DECODE;
         ST_DECODE: begin
            if (opc_s == OPC_NOP) begin
               next_state_s = ST_FETCH;
            end else if (opc_s == OPC_HALT) begin
               next_state_s = ST_HALT;
            end else begin
               next_state_s = ST_EXEC;
            end
         end
         ST_EXEC: begin
            case (opc_s)
               OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_XOR,
               OPC_SLL, OPC_SRL, OPC_SLT, OPC_ADDI: next_state_s = ST_WB;
               OPC_LW, OPC_SW:                      next_state_s = ST_MEM;
               default:                             next_state_s = ST_FETCH;
            endcase
         end
         ST_MEM:  next_state_s = (opc_s == OPC_LW) ? ST_WB : ST_FETCH;
         ST_WB:   next_state_s = ST_FETCH;
         ST_HALT: next_state_s = ST_HALT;
         default: next_state_s = ST_FETCH;
      endcase
   end

   // Moore outputs; reset forces every strobe idle and selects the reset PC.
   always_comb begin
      ir_write           = 1'b0;
      reg_write          = 1'b0;
      mem_select         = 1'b0;
      mem_to_reg         = 1'b0;
      mem_read_not_write = 1'b1;
      pc_source          = PCS_ALU;
      alu_src_a          = SRCA_PC;
      alu_src_b          = SRCB_REGB;
      alu_op             = ALU_ADD;
      if (reset) begin
         pc_source = PCS_RESET;
      end else begin
         case (state_r)
            ST_FETCH: begin
               ir_write  = 1'b1;
               alu_src_b = SRCB_ONE;
            end
            ST_DECODE: alu_src_b = SRCB_IMM;
            ST_EXEC: begin
               case (opc_s)
                  OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_XOR,
                  OPC_SLL, OPC_SRL, OPC_SLT: begin
                     alu_src_a = SRCA_REGA;
                     alu_op    = rtype_alu_op(opc_s);
                  end
                  OPC_ADDI, OPC_LW, OPC_SW: begin
                     alu_src_a = SRCA_REGA;
                     alu_src_b = SRCB_IMM;
                  end
                  OPC_BEQ, OPC_BNE: begin
                     alu_src_a = SRCA_REGA;
                     alu_op    = ALU_SUB;
                     pc_source = PCS_BUF;
                  end
                  OPC_JMP: pc_source = PCS_JUMP;
                  default: pc_source = PCS_ALU;
               endcase
            end
            ST_MEM: begin
               mem_select         = 1'b1;
               mem_read_not_write = (opc_s == OPC_LW);
            end
            ST_WB: begin
               reg_write  = 1'b1;
               mem_to_reg = (opc_s == OPC_LW);
            end
            ST_HALT: pc_source = PCS_ALU;
            default: pc_source = PCS_ALU;
         endcase
      end
   end

   // PC write kept apart from the strobes so zero never feeds back into alu_op.
   always_comb begin
      pc_write = 1'b0;
      if (reset) begin
         pc_write = 1'b0;
      end else begin
         case (state_r)
            ST_FETCH: pc_write = 1'b1;
            ST_EXEC: begin
               case (opc_s)
                  OPC_BEQ: pc_write = zero;
                  OPC_BNE: pc_write = ~zero;
                  OPC_JMP: pc_write = 1'b1;
                  default: pc_write = 1'b0;
               endcase
            end
            default: pc_write = 1'b0;
         endcase
      end
   end

endmodule

// File: rtl/mcc_control_unit.sv
// Sequencing core of the multi-cycle CPU: control FSM, ALU and the PC register.
module mcc_control_unit
   import mcc_control_unit_pkg::*;
#(
   parameter int                DATA_W   = DATA_W_DEF,
   parameter int                ADDR_W   = ADDR_W_DEF,
   parameter int                OP_W     = OP_W_DEF,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(1024)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [OP_W-1:0]   opcode,
   input  logic [DATA_W-1:0] alu_a,
   input  logic [DATA_W-1:0] alu_b,
   input  logic [ADDR_W-1:0] next_pc,
   output logic [DATA_W-1:0] alu_result,
   output logic              zero,
   output logic [ADDR_W-1:0] pc,
   output logic              ir_write,
   output logic              reg_write,
   output logic              mem_select,
   output logic              mem_to_reg,
   output logic              mem_read_not_write,
   output logic [1:0]        pc_source,
   output logic              alu_src_a,
   output logic [1:0]        alu_src_b,
   output logic [3:0]        alu_op
);

   logic              pc_write_s;
   logic [ADDR_W-1:0] pc_r;

   mcc_fsm #(
      .OP_W (OP_W)
   ) u_fsm (
      .clock              (clock),
      .reset              (reset),
      .opcode             (opcode),
      .zero               (zero),
      .ir_write           (ir_write),
      .reg_write          (reg_write),
      .mem_select         (mem_select),
      .mem_to_reg         (mem_to_reg),
      .mem_read_not_write (mem_read_not_write),
      .pc_source          (pc_source),
      .alu_src_a          (alu_src_a),
      .alu_src_b          (alu_src_b),
      .alu_op             (alu_op),
      .pc_write           (pc_write_s)
   );

   mcc_alu #(
      .DATA_W (DATA_W)
   ) u_alu (
      .alu_op (alu_op),
      .a      (alu_a),
      .b      (alu_b),
      .result (alu_result),
      .zero   (zero)
   );

   // PC register; only ever updated on an edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         pc_r <= RESET_PC;
      end else if (pc_write_s) begin
         pc_r <= next_pc;
      end else begin
         pc_r <= pc_r;
      end
   end

   assign pc = pc_r;

endmodule

// File: tb/tb_mcc_control_unit.sv
// Scoreboard bench for mcc_control_unit: per-cycle expected outputs are queued
// as each instruction is launched and compared cycle by cycle.
module tb_mcc_control_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic [3:0]  opcode;
   logic [23:0] alu_a, alu_b;
   logic [10:0] next_pc;
   logic [23:0] alu_result;
   logic        zero;
   logic [10:0] pc;
   logic        ir_write, reg_write, mem_select, mem_to_reg, mem_read_not_write;
   logic [1:0]  pc_source;
   logic        alu_src_a;
   logic [1:0]  alu_src_b;
   logic [3:0]  alu_op;

   mcc_control_unit dut (
      .clock (clock), .reset (reset), .opcode (opcode),
      .alu_a (alu_a), .alu_b (alu_b), .next_pc (next_pc),
      .alu_result (alu_result), .zero (zero), .pc (pc),
      .ir_write (ir_write), .reg_write (reg_write), .mem_select (mem_select),
      .mem_to_reg (mem_to_reg), .mem_read_not_write (mem_read_not_write),
      .pc_source (pc_source), .alu_src_a (alu_src_a), .alu_src_b (alu_src_b),
      .alu_op (alu_op)
   );

   always #5 clock = ~clock;

   localparam int SF = 0, SD = 1, SE = 2, SM = 3, SWB = 4, SH = 5, SR = 6;

   typedef struct {
      logic [13:0] ctl;
      logic [10:0] pc;
      logic [23:0] res;
      logic        z;
   } exp_t;

   typedef struct {
      logic [10:0] np;
      logic        rst;
   } stim_t;

   exp_t        exp_q[$];
   stim_t       stim_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [10:0] pc_model;
   int          np_override = -1;

   wire [13:0] ctl_obs = {ir_write, reg_write, mem_select, mem_to_reg, mem_read_not_write,
                          pc_source, alu_src_a, alu_src_b, alu_op};

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      if (obs !== expv) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [13:0] pack(input logic ir, rw, ms, m2r, rnw, input logic [1:0] ps,
                                        input logic sa, input logic [1:0] sb, input logic [3:0] op);
      return {ir, rw, ms, m2r, rnw, ps, sa, sb, op};
   endfunction

   function automatic logic [3:0] r_op(input logic [3:0] opc);
      case (opc)
         4'd1: return 4'd0;  4'd2: return 4'd1;  4'd3: return 4'd2;  4'd4: return 4'd3;
         4'd5: return 4'd4;  4'd6: return 4'd5;  4'd7: return 4'd6;  4'd14: return 4'd7;
         default: return 4'd15;
      endcase
   endfunction

   function automatic logic [23:0] alu_m(input logic [3:0] op, input logic [23:0] a, b);
      case (op)
         4'd0: return a + b;
         4'd1: return a - b;
         4'd2: return a & b;
         4'd3: return a | b;
         4'd4: return a ^ b;
         4'd5: return (b[4:0] >= 5'd24) ? 24'd0 : (a << b[4:0]);
         4'd6: return (b[4:0] >= 5'd24) ? 24'd0 : (a >> b[4:0]);
         4'd7: return ($signed(a) < $signed(b)) ? 24'd1 : 24'd0;
         4'd8: return b;
         default: return 24'd0;
      endcase
   endfunction

   // Queue one cycle of stimulus and its expected outputs; advances the PC model.
   task automatic push_cycle(input int st, input logic chk_res, input logic [23:0] res_k);
      exp_t  e;
      stim_t s;
      logic  pcw = 1'b0;
      s.np  = 11'($urandom_range(0, 2047));
      s.rst = (st == SR);
      if (np_override >= 0) begin
         s.np = 11'(np_override);
         np_override = -1;
      end
      case (st)
         SF: begin e.ctl = pack(1, 0, 0, 0, 1, 2'd0, 0, 2'd1, 4'd0); pcw = 1'b1; end
         SD: e.ctl = pack(0, 0, 0, 0, 1, 2'd0, 0, 2'd2, 4'd0);
         SE: begin
            if (r_op(opcode) != 4'd15)
               e.ctl = pack(0, 0, 0, 0, 1, 2'd0, 1, 2'd0, r_op(opcode));
            else if (opcode inside {4'd8, 4'd9, 4'd10})
               e.ctl = pack(0, 0, 0, 0, 1, 2'd0, 1, 2'd2, 4'd0);
            else if (opcode inside {4'd11, 4'd12}) begin
               e.ctl = pack(0, 0, 0, 0, 1, 2'd1, 1, 2'd0, 4'd1);
               pcw = (opcode == 4'd11) ? (alu_a == alu_b) : (alu_a != alu_b);
            end else begin
               e.ctl = pack(0, 0, 0, 0, 1, 2'd2, 0, 2'd0, 4'd0);
               pcw = 1'b1;
            end
         end
         SM:  e.ctl = pack(0, 0, 1, 0, (opcode == 4'd9), 2'd0, 0, 2'd0, 4'd0);
         SWB: e.ctl = pack(0, 1, 0, (opcode == 4'd9), 1, 2'd0, 0, 2'd0, 4'd0);
         SR:  e.ctl = pack(0, 0, 0, 0, 1, 2'd3, 0, 2'd0, 4'd0);
         default: e.ctl = pack(0, 0, 0, 0, 1, 2'd0, 0, 2'd0, 4'd0);
      endcase
      e.res = alu_m(e.ctl[3:0], alu_a, alu_b);
      if (chk_res && st == SE) e.res = res_k;
      e.z  = (e.res == 24'd0);
      e.pc = pc_model;
      if (st == SR) pc_model = 11'd1024;
      else if (pcw) pc_model = s.np;
      exp_q.push_back(e);
      stim_q.push_back(s);
   endtask

   // Apply queued stimulus and compare DUT outputs at each falling edge.
   task automatic drain(input string name);
      exp_t  e;
      stim_t s;
      int    c = 0;
      while (exp_q.size() > 0) begin
         s = stim_q.pop_front();
         reset   = s.rst;
         next_pc = s.np;
         @(negedge clock);
         e = exp_q.pop_front();
         check_eq($sformatf("%s c%0d ctl", name, c), 32'(ctl_obs), 32'(e.ctl));
         check_eq($sformatf("%s c%0d pc", name, c), 32'(pc), 32'(e.pc));
         check_eq($sformatf("%s c%0d alu", name, c), 32'(alu_result), 32'(e.res));
         check_eq($sformatf("%s c%0d zero", name, c), 32'(zero), 32'(e.z));
         @(posedge clock);
         #1;
         c++;
      end
      reset = 1'b0;
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) push_cycle(SR, 1'b0, 24'd0);
      drain("reset");
   endtask

   task automatic run_instr(input string name, input logic [3:0] op, input logic [23:0] a, b,
                            input logic chk, input logic [23:0] res_k, input int abort = 0);
      int sts[$];
      opcode = op;
      alu_a  = a;
      alu_b  = b;
      sts = '{SF, SD};
      case (op)
         4'd0:                      ;
         4'd15:                     for (int i = 0; i < 10; i++) sts.push_back(SH);
         4'd11, 4'd12, 4'd13:       sts.push_back(SE);
         4'd9:                      begin sts.push_back(SE); sts.push_back(SM); sts.push_back(SWB); end
         4'd10:                     begin sts.push_back(SE); sts.push_back(SM); end
         default:                   begin sts.push_back(SE); sts.push_back(SWB); end
      endcase
      if (abort > 0)
         while (sts.size() > abort) void'(sts.pop_back());
      foreach (sts[i]) push_cycle(sts[i], chk, res_k);
      drain(name);
   endtask

   initial begin
      reset   = 1'b1;
      opcode  = 4'd0;
      alu_a   = 24'd0;
      alu_b   = 24'd0;
      next_pc = 11'd0;
      @(posedge clock);
      #1;
      pc_model = 11'd1024;
      do_reset(2);

      np_override = 1025;
      run_instr("add", 4'd1, 24'd3, 24'd4, 1'b1, 24'd7);
      run_instr("sub_wrap", 4'd2, 24'd0, 24'd1, 1'b1, 24'hFFFFFF);
      run_instr("add_zero", 4'd1, 24'h800000, 24'h800000, 1'b1, 24'd0);
      run_instr("slt_neg", 4'd14, 24'hFFFFFF, 24'd1, 1'b1, 24'd1);
      run_instr("sll_24", 4'd6, 24'd1, 24'd24, 1'b1, 24'd0);
      run_instr("sll_3", 4'd6, 24'h000005, 24'd3, 1'b1, 24'h000028);
      run_instr("srl_4", 4'd7, 24'h800000, 24'd4, 1'b1, 24'h080000);
      run_instr("and", 4'd3, 24'hF0F0F0, 24'h3C3C3C, 1'b1, 24'h303030);
      run_instr("or", 4'd4, 24'hF0F0F0, 24'h0F0000, 1'b1, 24'hFFF0F0);
      run_instr("xor", 4'd5, 24'hFFFFFF, 24'h0000FF, 1'b1, 24'hFFFF00);
      run_instr("nop", 4'd0, 24'd9, 24'd9, 1'b0, 24'd0);
      run_instr("addi", 4'd8, 24'd100, 24'd23, 1'b1, 24'd123);
      run_instr("lw", 4'd9, 24'd10, 24'd2, 1'b0, 24'd0);
      run_instr("sw", 4'd10, 24'd10, 24'd2, 1'b0, 24'd0);
      run_instr("beq_eq", 4'd11, 24'd5, 24'd5, 1'b1, 24'd0);
      run_instr("beq_ne", 4'd11, 24'd5, 24'd6, 1'b1, 24'hFFFFFF);
      run_instr("bne_eq", 4'd12, 24'd5, 24'd5, 1'b0, 24'd0);
      run_instr("bne_ne", 4'd12, 24'd5, 24'd6, 1'b0, 24'd0);
      run_instr("jmp", 4'd13, 24'd1, 24'd2, 1'b0, 24'd0);
      run_instr("lw_abort", 4'd9, 24'd4, 24'd4, 1'b0, 24'd0, 3);
      do_reset(1);
      run_instr("sw_after_rst", 4'd10, 24'd1, 24'd1, 1'b0, 24'd0);
      run_instr("halt", 4'd15, 24'd0, 24'd0, 1'b0, 24'd0);
      do_reset(1);
      run_instr("nop_after_halt", 4'd0, 24'd0, 24'd0, 1'b0, 24'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
